branch_predictor_gshare: RTL
============================

// Module: branch_predictor_gshare
// PURPOSE
//  Parametrised instruction-fetch direction predictor: gshare PHT of 2-bit saturating counters plus a
//  speculative global-history register (GHR) with checkpoint recovery. Predicts each decoded branch
//  in the fetch cycle, tracks in-flight branches in an in-order queue, and resolves them from the CDB.
//  Mispredicts are signalled to fetch together with the redirect address. Exports a queue-full stall
//  and performance counters. Sits between the decoder/fetch unit and the CDB.
// PARAMETERS
//  PHT_ENTRIES  64     PHT size, power of two; IDX_W = $clog2(PHT_ENTRIES)
//  HIST_W       6      GHR length, 0..IDX_W; 0 = bimodal mode (index = pc[IDX_W:1], no GHR)
//  Q_DEPTH      8      in-flight branch queue depth, power of two, >=2
//  CNT_W        32     width of each performance counter
//  INIT_STATE   2'b01  PHT reset state (WNT)
// PORTS
//  clk_in        in   1      clock
//  rst_in        in   1      synchronous active-high reset
//  rdy_in        in   1      global ready; low = hold all state
//  branch        in   1      decoded instruction at pc_in is a conditional branch
//  imm           in   32     branch offset, sign-extended
//  inst_length   in   1      1 = 32-bit inst (next pc +4), 0 = compressed (+2)
//  foq_full      in   1      fetch output queue full; suppresses prediction
//  pc_in         in   32     pc of decoded instruction
//  cdb_active    in   1      CDB broadcast valid
//  cdb_addr      in   32     pc of the broadcasting instruction
//  cdb_val       in   32     result; bit 0 = branch actually taken
//  q_full        out  1      in-flight queue full; fetch must stall branches
//  need_branch   out  1      predicted taken
//  branch_addr   out  32     next fetch pc per prediction
//  predict_fail  out  1      head branch mispredicted (one-cycle pulse)
//  fail_addr     out  32     correct redirect pc, valid with predict_fail
//  perf_resolved out  CNT_W  branches resolved since reset
//  perf_mispred  out  CNT_W  mispredicts since reset
// BEHAVIOUR
//  - need_predict = branch & rdy_in & !foq_full & !q_full & !predict_fail. All prediction outputs are
//    combinational and read the current PHT/GHR; they are 0 (branch_addr 32'b0) when !need_predict.
//  - idx = pc_in[IDX_W:1] ^ {zero-ext GHR}; need_branch = PHT[idx] >= 2'b10;
//    taken tgt = pc_in+imm, fall tgt = pc_in+(inst_length?4:2), 32-bit wrap; fail addr = the other one.
//  - Push (posedge, need_predict): enqueue {pc, fail addr, pred, idx, GHR before update};
//    GHR <= {GHR[HIST_W-2:0], pred}.
//  - resolve = rdy_in & cdb_active & !empty & cdb_addr==head.pc & cdb_addr!=0.
//    predict_fail = resolve & (head.pred != cdb_val[0]); fail_addr = head.fail when set, else 0.
//  - On resolve: PHT[head.idx] saturating +1 if taken / -1 if not (clamped at 11/00);
//    perf_resolved++; perf_mispred++ on fail; counters wrap at 2^CNT_W.
//  - Correct resolve: pop head. Mispredict: flush queue (empty next cycle),
//    GHR <= {head.ghr[HIST_W-2:0], cdb_val[0]}; same-cycle push suppressed.
//  - Push + correct pop same cycle: both occur, occupancy unchanged.
//  - q_full = (count == Q_DEPTH) from registered count only (no same-cycle pop credit).
//  - Pointers wrap modulo Q_DEPTH; count is $clog2(Q_DEPTH)+1 bits.
//  - PHT read/write same idx in one cycle: prediction sees old value (no bypass).
//  - CDB addr matching a non-head entry, or arriving while queue empty: ignored.
//  - rdy_in low: no state change; predict_fail and need_branch are 0.
//  - Reset (any cycle, incl. mid-flush): PHT = INIT_STATE, GHR = 0, queue empty,
//    perf counters 0; outputs 0 with q_full = 0.
// STRUCTURE
//  - bp_pkg: localparams SNT/WNT/WT/ST, entry-field widths/offsets, next-pc offset constants.
//  - Sub-module bp_inflight_fifo: parametrised entry-width circular FIFO with push/pop/flush,
//    head peek, count, full/empty. PHT, GHR and perf counters stay in the top level.
// TESTING
//  - Reset, branch at pc 0x100, imm 0x40, len 1 -> need_branch 0, branch_addr 0x104; queue count 1.
//  - Same pc resolved taken 2x (HIST_W=0) -> 3rd predict need_branch 1, branch_addr 0x140.
//  - Predict NT at 0x100, CDB {0x100, val 1} -> predict_fail 1, fail_addr 0x140; queue empty,
//    GHR = {snapshot,1}; perf_mispred 1.
//  - Push Q_DEPTH=8 branches without resolve -> q_full 1, 9th branch not pushed, all outputs 0.
//  - Push and correct pop in same cycle at count 3 -> count stays 3, front/rear both advance.
//  - HIST_W=2, GHR 2'b11, pc 0x8 -> PHT index 4^3 = 7 is read; rdy_in low 5 cycles -> state frozen.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared constants for the gshare direction predictor: counter states,
// next-pc offsets and the in-flight entry layout helper.
package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam int PC_W = 32;

  localparam logic [PC_W-1:0] NPC_LONG  = 32'd4;
  localparam logic [PC_W-1:0] NPC_SHORT = 32'd2;

  // Entry layout, LSB first: ghr | idx | pred | fail_addr | pc
  function automatic int entry_w(input int idx_w, input int ghr_w);
    return ghr_w + idx_w + 1 + 2 * PC_W;
  endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// Circular FIFO of in-flight branch entries with push/pop/flush, head peek
// and occupancy count.
module bp_inflight_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [W-1:0]             i_din,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_front;
  logic [PW-1:0] r_rear;
  logic [PW:0]   r_count;
  logic          w_full;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_full    = (r_count == (PW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~w_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_head    = r_mem[r_front];
  assign o_count   = r_count;

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_rear] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_front <= '0;
      r_rear  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_rear <= r_rear + PW'(1);
      if (w_do_pop) r_front <= r_front + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Gshare direction predictor: PHT of 2-bit counters indexed by pc ^ GHR,
// speculative GHR with per-branch checkpoints, in-order resolution from the CDB.
module branch_predictor_gshare
  import bp_pkg::*;
#(
  parameter int         PHT_ENTRIES = 64,
  parameter int         HIST_W      = 6,
  parameter int         Q_DEPTH     = 8,
  parameter int         CNT_W       = 32,
  parameter logic [1:0] INIT_STATE  = WNT
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             branch,
  input  logic [31:0]      imm,
  input  logic             inst_length,
  input  logic             foq_full,
  input  logic [31:0]      pc_in,
  input  logic             cdb_active,
  input  logic [31:0]      cdb_addr,
  input  logic [31:0]      cdb_val,
  output logic             q_full,
  output logic             need_branch,
  output logic [31:0]      branch_addr,
  output logic             predict_fail,
  output logic [31:0]      fail_addr,
  output logic [CNT_W-1:0] perf_resolved,
  output logic [CNT_W-1:0] perf_mispred
);
  localparam int IDX_W    = $clog2(PHT_ENTRIES);
  localparam int GHR_W    = (HIST_W > 0) ? HIST_W : 1;
  localparam int QC_W     = $clog2(Q_DEPTH) + 1;
  localparam int IDX_OFF  = GHR_W;
  localparam int PRED_OFF = IDX_OFF + IDX_W;
  localparam int FAIL_OFF = PRED_OFF + 1;
  localparam int PC_OFF   = FAIL_OFF + PC_W;
  localparam int ENT_W    = entry_w(IDX_W, GHR_W);

  logic [1:0]       r_pht [PHT_ENTRIES];
  logic [GHR_W-1:0] r_ghr;
  logic [CNT_W-1:0] r_perf_res;
  logic [CNT_W-1:0] r_perf_mis;

  logic [ENT_W-1:0] w_head;
  logic [ENT_W-1:0] w_push_ent;
  logic [QC_W-1:0]  w_count;
  logic             w_empty;
  logic [IDX_W-1:0] w_ghr_ext;
  logic [IDX_W-1:0] w_idx;
  logic             w_pred;
  logic [31:0]      w_tgt_taken;
  logic [31:0]      w_tgt_fall;
  logic [31:0]      w_head_pc;
  logic [31:0]      w_head_fail;
  logic             w_head_pred;
  logic [IDX_W-1:0] w_head_idx;
  logic [GHR_W-1:0] w_head_ghr;
  logic             w_taken;
  logic             w_resolve;
  logic             w_fail;
  logic             w_need_predict;
  logic             w_unused;

  assign w_head_pc   = w_head[PC_OFF +: PC_W];
  assign w_head_fail = w_head[FAIL_OFF +: PC_W];
  assign w_head_pred = w_head[PRED_OFF];
  assign w_head_idx  = w_head[IDX_OFF +: IDX_W];
  assign w_head_ghr  = w_head[0 +: GHR_W];
  assign w_taken     = cdb_val[0];
  assign w_unused    = &{1'b0, cdb_val[31:1]};

  assign w_ghr_ext   = (HIST_W == 0) ? '0 : IDX_W'(r_ghr);
  assign w_idx       = pc_in[IDX_W:1] ^ w_ghr_ext;
  assign w_pred      = (r_pht[w_idx] >= WT);
  assign w_tgt_taken = pc_in + imm;
  assign w_tgt_fall  = pc_in + (inst_length ? NPC_LONG : NPC_SHORT);

  assign q_full    = (w_count == QC_W'(Q_DEPTH));
  assign w_resolve = ~rst_in & rdy_in & cdb_active & ~w_empty &
                     (cdb_addr == w_head_pc) & (cdb_addr != '0);
  assign w_fail    = w_resolve & (w_head_pred != w_taken);
  assign w_need_predict = ~rst_in & branch & rdy_in & ~foq_full & ~q_full & ~w_fail;

  assign need_branch   = w_need_predict & w_pred;
  assign branch_addr   = w_need_predict ? (w_pred ? w_tgt_taken : w_tgt_fall) : 32'b0;
  assign predict_fail  = w_fail;
  assign fail_addr     = w_fail ? w_head_fail : 32'b0;
  assign perf_resolved = r_perf_res;
  assign perf_mispred  = r_perf_mis;

  // The stored redirect is the path not predicted.
  assign w_push_ent = {pc_in, (w_pred ? w_tgt_fall : w_tgt_taken), w_pred, w_idx, r_ghr};

  bp_inflight_fifo #(
    .W     (ENT_W),
    .DEPTH (Q_DEPTH)
  ) u_fifo (
    .i_clk   (clk_in),
    .i_rst   (rst_in),
    .i_push  (w_need_predict),
    .i_pop   (w_resolve & ~w_fail),
    .i_flush (w_fail),
    .i_din   (w_push_ent),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < PHT_ENTRIES; i++) r_pht[i] <= INIT_STATE;
    end else if (w_resolve) begin
      if (w_taken && r_pht[w_head_idx] != ST)
        r_pht[w_head_idx] <= r_pht[w_head_idx] + 2'd1;
      else if (!w_taken && r_pht[w_head_idx] != SNT)
        r_pht[w_head_idx] <= r_pht[w_head_idx] - 2'd1;
    end
  end

  // Mispredict restores the checkpoint with the actual outcome appended.
  always_ff @(posedge clk_in) begin
    if (rst_in || HIST_W == 0) r_ghr <= '0;
    else if (w_fail) r_ghr <= (w_head_ghr << 1) | GHR_W'(w_taken);
    else if (w_need_predict) r_ghr <= (r_ghr << 1) | GHR_W'(w_pred);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_perf_res <= '0;
      r_perf_mis <= '0;
    end else if (w_resolve) begin
      r_perf_res <= r_perf_res + CNT_W'(1);
      if (w_fail) r_perf_mis <= r_perf_mis + CNT_W'(1);
    end
  end

endmodule
